// File: rtl/hv_alu_ctrl.sv
// Command sequencer for an external hypervector ALU PE: iterates each command N times with
// ALU feedback into operand A, then latches the result. Optional perf counters: HV_ALU_CTRL_PERF_EN.
module hv_alu_ctrl #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned NumOps      = 8,
  parameter int unsigned NumOpsWidth = $clog2(NumOps),
  parameter int unsigned MaxShiftAmt = 4,
  parameter int unsigned ShiftWidth  = $clog2(MaxShiftAmt),
  parameter int unsigned IterWidth   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [NumOpsWidth-1:0] cmd_op_i,
  input  logic [ShiftWidth-1:0]  cmd_shift_amt_i,
  input  logic                   cmd_src_acc_i,
  input  logic [IterWidth-1:0]   cmd_iter_i,
  input  logic [HVDimension-1:0] hv_a_i,
  input  logic [HVDimension-1:0] hv_b_i,
  input  logic                   acc_clr_i,
  output logic [HVDimension-1:0] alu_a_o,
  output logic [HVDimension-1:0] alu_b_o,
  output logic [NumOpsWidth-1:0] alu_op_o,
  output logic [ShiftWidth-1:0]  alu_shift_amt_o,
  input  logic [HVDimension-1:0] alu_c_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [HVDimension-1:0] res_o,
  output logic                   busy_o,
  output logic [31:0]            perf_cmd_cnt_o,
  output logic [31:0]            perf_busy_cnt_o
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e                 state_q;
  logic [HVDimension-1:0] op_a_q, op_b_q, acc_q;
  logic [NumOpsWidth-1:0] op_q;
  logic [ShiftWidth-1:0]  shift_q;
  logic [IterWidth-1:0]   cnt_q;
  logic                   cmd_ready_q, res_valid_q, busy_q;

  logic accept, in_exec;
  assign accept  = (state_q == IDLE) && cmd_valid_i;
  assign in_exec = (state_q == EXEC);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_q        <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_clr_i) acc_q <= '0;
          if (cmd_valid_i) begin
            op_q    <= cmd_op_i;
            shift_q <= cmd_shift_amt_i;
            op_b_q  <= hv_b_i;
            // A pending clear wins over the accumulator as operand source.
            op_a_q  <= cmd_src_acc_i ? (acc_clr_i ? '0 : acc_q) : hv_a_i;
            cnt_q   <= (cmd_iter_i == '0) ? IterWidth'(1) : cmd_iter_i;
            state_q     <= EXEC;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        EXEC: begin
          op_a_q <= alu_c_i;
          if (cnt_q != '0) cnt_q <= cnt_q - IterWidth'(1);
          if (cnt_q <= IterWidth'(1)) begin
            acc_q       <= alu_c_i;
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o     = cmd_ready_q;
  assign res_valid_o     = res_valid_q;
  assign busy_o          = busy_q;
  assign res_o           = acc_q;
  assign alu_a_o         = op_a_q;
  assign alu_b_o         = op_b_q;
  assign alu_op_o        = op_q;
  assign alu_shift_amt_o = shift_q;

`ifdef HV_ALU_CTRL_PERF_EN
  logic [31:0] perf_cmd_q, perf_busy_q;

  // Saturating counters: stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cmd_q  <= '0;
      perf_busy_q <= '0;
    end else begin
      if (accept && (perf_cmd_q != '1))   perf_cmd_q  <= perf_cmd_q + 32'd1;
      if (in_exec && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
    end
  end

  assign perf_cmd_cnt_o  = perf_cmd_q;
  assign perf_busy_cnt_o = perf_busy_q;
`else
  logic unused_perf;
  assign unused_perf     = accept ^ in_exec;
  assign perf_cmd_cnt_o  = '0;
  assign perf_busy_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hv_alu_ctrl.sv
// Self-checking bench for hv_alu_ctrl: behavioural ALU drives alu_c_i, a per-command
// reference model computes expected results, latency, and accumulator chaining.
module tb_hv_alu_ctrl;
  localparam int D = 512;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid, cmd_ready, cmd_src_acc, acc_clr;
  logic [2:0]     cmd_op;
  logic [1:0]     cmd_shift;
  logic [7:0]     cmd_iter;
  logic [D-1:0]   hv_a, hv_b, alu_a, alu_b, alu_c, res;
  logic [2:0]     alu_op;
  logic [1:0]     alu_shift;
  logic           res_valid, res_ready, busy;
  logic [31:0]    perf_cmd, perf_busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [D-1:0] m_acc = '0;
  int exp_cmds = 0;
  int exp_busy = 0;

  always #5 clk = ~clk;

  hv_alu_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_shift_amt_i(cmd_shift), .cmd_src_acc_i(cmd_src_acc),
    .cmd_iter_i(cmd_iter), .hv_a_i(hv_a), .hv_b_i(hv_b), .acc_clr_i(acc_clr),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_shift_amt_o(alu_shift),
    .alu_c_i(alu_c), .res_valid_o(res_valid), .res_ready_i(res_ready), .res_o(res),
    .busy_o(busy), .perf_cmd_cnt_o(perf_cmd), .perf_busy_cnt_o(perf_busy)
  );

  function automatic logic [D-1:0] ref_alu(input logic [2:0] op, input logic [1:0] sh,
                                           input logic [D-1:0] a, input logic [D-1:0] b);
    int s;
    case (sh)
      2'd0: s = 1;
      2'd1: s = 4;
      2'd2: s = 8;
      default: s = 16;
    endcase
    case (op)
      3'd1: return a;
      3'd2: return b;
      3'd3: return (a >> s) | (a << (D - s));
      3'd4: return (a << s) | (a >> (D - s));
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_c = ref_alu(alu_op, alu_shift, alu_a, alu_b);

  task automatic check(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_perf();
`ifdef HV_ALU_CTRL_PERF_EN
    check("perf_cmd", D'(perf_cmd), D'(exp_cmds));
    check("perf_busy", D'(perf_busy), D'(exp_busy));
`else
    check("perf_cmd_tied", D'(perf_cmd), '0);
    check("perf_busy_tied", D'(perf_busy), '0);
`endif
  endtask

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] sh, input logic src,
                         input logic [7:0] iter, input logic [D-1:0] a, input logic [D-1:0] b,
                         input logic clr, input int hold, output logic [D-1:0] got);
    logic [D-1:0] r, held;
    int n, lat;
    n = (iter == 0) ? 1 : int'(iter);
    r = src ? (clr ? '0 : m_acc) : a;
    for (int i = 0; i < n; i++) r = ref_alu(op, sh, r, b);
    m_acc = r;

    check("cmd_ready_idle", D'(cmd_ready), D'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_shift = sh; cmd_src_acc = src;
    cmd_iter = iter; hv_a = a; hv_b = b; acc_clr = clr;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; acc_clr = 1'b0;
    hv_a = {16{$urandom}}; hv_b = {16{$urandom}};
    check("busy_exec", D'(busy), D'(1));
    check("alu_op_fwd", D'(alu_op), D'(op));
    lat = 0;
    while (!res_valid && lat < 300) begin
      lat++;
      @(negedge clk);
    end
    check("latency", D'(lat), D'(n));
    check("result", res, r);
    got = res;
    held = res;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_src_acc = 1'b0; hv_a = {16{$urandom}};
      @(negedge clk);
      check("hold_res", res, held);
      check("hold_valid", D'(res_valid), D'(1));
      check("hold_ready", D'(cmd_ready), D'(0));
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("release_valid", D'(res_valid), D'(0));
    check("release_ready", D'(cmd_ready), D'(1));
    exp_cmds++;
    exp_busy += n;
    check_perf();
  endtask

  initial begin
    logic [D-1:0] got, e;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_shift = '0; cmd_src_acc = 1'b0;
    cmd_iter = '0; hv_a = '0; hv_b = '0; acc_clr = 1'b0; res_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", D'(cmd_ready), D'(1));
    check("rst_valid", D'(res_valid), D'(0));
    check("rst_busy", D'(busy), D'(0));
    check("rst_res", res, '0);
    check("rst_alu_a", alu_a, '0);
    check("rst_alu_b", alu_b, '0);
    rst = 1'b0;
    @(negedge clk);
    check_perf();

    run_cmd(3'd0, 2'd0, 1'b0, 8'd1, D'('hF0), D'('hFF), 1'b0, 0, got);
    check("xor_iter1", got, D'('h0F));
    run_cmd(3'd0, 2'd0, 1'b0, 8'd2, D'('hF0), D'('hFF), 1'b0, 0, got);
    check("xor_iter2", got, D'('hF0));
    run_cmd(3'd3, 2'd1, 1'b0, 8'd3, D'(1), '0, 1'b0, 0, got);
    e = '0; e[500] = 1'b1;
    check("rotr_bit500", got, e);
    run_cmd(3'd4, 2'd1, 1'b0, 8'd3, D'(1), '0, 1'b0, 0, got);
    e = '0; e[12] = 1'b1;
    check("rotl_bit12", got, e);
    run_cmd(3'd1, 2'd0, 1'b0, 8'd1, D'('hAB), D'('h5), 1'b0, 0, got);
    check("pass_a", got, D'('hAB));
    run_cmd(3'd4, 2'd0, 1'b1, 8'd1, D'('h3), D'('h5), 1'b0, 0, got);
    check("chain_acc", got, D'('h156));
    run_cmd(3'd1, 2'd0, 1'b1, 8'd1, D'('h77), D'('h5), 1'b1, 0, got);
    check("clr_priority", got, '0);
    run_cmd(3'd0, 2'd0, 1'b0, 8'd0, D'('hF0), D'('hFF), 1'b0, 5, got);
    check("iter0_as_1", got, D'('h0F));
    run_cmd(3'd2, 2'd0, 1'b0, 8'd4, D'('h1), D'('hBEEF), 1'b0, 0, got);
    check("pass_b", got, D'('hBEEF));

    // Reset in the second EXEC cycle of an iter=5 command.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_src_acc = 1'b0; cmd_iter = 8'd5;
    hv_a = D'('h1234); hv_b = D'('h99);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("busy_before_rst", D'(busy), D'(1));
    rst = 1'b1;
    #1;
    check("rst_async_ready", D'(cmd_ready), D'(1));
    @(negedge clk);
    rst = 1'b0;
    m_acc = '0; exp_cmds = 0; exp_busy = 0;
    @(negedge clk);
    check("post_rst_ready", D'(cmd_ready), D'(1));
    check("post_rst_acc", res, '0);
    check_perf();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_result", D'(res_valid), D'(0));
    end

    for (int k = 0; k < 40; k++) begin
      run_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom),
              8'($urandom_range(0, 6)), {16{$urandom}}, {16{$urandom}},
              ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
